universal_shift_register: RTL and testbench

//  Parametrised multi-mode shift register for datapath and serial-protocol blocks.

---
 rtl/usr_pkg.sv | 21 ++
 rtl/usr_barrel_shift_core.sv | 78 +++++++
 rtl/universal_shift_register.sv | 154 +++++++++++++++
 tb/tb_universal_shift_register.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the universal shift register.
//   shift_op_t  : shift operation encoding. Codes 3'b110 and 3'b111 are reserved
//                 and behave as NOP.
//   usr_state_t : sequencer state.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_SLL = 3'b001,
        OP_SRL = 3'b010,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } usr_state_t;

endpackage

// File: rtl/usr_barrel_shift_core.sv
// barrel_shift_core: combinational single-step shifter.
//   in    : value to shift
//   amt   : shift amount, 0..WIDTH-1
//   op    : raw 3-bit op code (shift_op_t values; reserved codes act as NOP)
//   fill  : value for vacated bits on SLL/SRL
//   out   : shifted result
//   shout : last bit leaving its position (0 for NOP or amt=0)
module barrel_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [2:0]         op,
    input  logic               fill,
    output logic [WIDTH-1:0]   out,
    output logic               shout
);

    logic [WIDTH-1:0]   lo_mask;
    logic [WIDTH-1:0]   hi_mask;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;
    logic               left_bit;
    logic               right_bit;
    int                 amt_i;

    assign amt_i   = int'(amt);
    // Masks covering the bits vacated by a left / right shift of amt.
    assign lo_mask = ~({WIDTH{1'b1}} << amt);
    assign hi_mask = ~({WIDTH{1'b1}} >> amt);
    // Rotates via a doubled word: the wanted window falls out of a plain shift.
    assign rol_w   = {in, in} << amt;
    assign ror_w   = {in, in} >> amt;

    always_comb begin
        left_bit  = 1'b0;
        right_bit = 1'b0;
        if (amt_i != 0) begin
            left_bit  = in[WIDTH - amt_i];
            right_bit = in[amt_i - 1];
        end
    end

    always_comb begin
        out   = in;
        shout = 1'b0;
        case (op)
            OP_SLL: begin
                out   = (in << amt) | (fill ? lo_mask : '0);
                shout = left_bit;
            end
            OP_SRL: begin
                out   = (in >> amt) | (fill ? hi_mask : '0);
                shout = right_bit;
            end
            OP_SRA: begin
                out   = $unsigned($signed(in) >>> amt);
                shout = right_bit;
            end
            OP_ROL: begin
                out   = rol_w[2*WIDTH-1:WIDTH];
                shout = left_bit;
            end
            OP_ROR: begin
                out   = ror_w[WIDTH-1:0];
                shout = right_bit;
            end
            default: begin
                out   = in;
                shout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: multi-mode shift register running COUNT-step
// shift sequences under a start/busy/done handshake.
//   clock, preset_L : rising-edge clock, async active-low reset
//   d, load         : parallel load (aborts a running sequence)
//   start           : begin a sequence (honoured in IDLE only)
//   op/amt/fill/count : sequence setup, captured on the start edge
//   Q, cout         : register contents, last bit shifted out
//   busy, done      : sequence in progress, one-cycle completion pulse
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SHAMT_W   = $clog2(WIDTH),
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clock,
    input  logic               preset_L,
    input  logic [WIDTH-1:0]   d,
    input  logic               load,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] amt,
    input  logic               fill,
    input  logic [CNT_W-1:0]   count,
    output logic [WIDTH-1:0]   Q,
    output logic               cout,
    output logic               busy,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    usr_state_t         state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         op_q, op_d;
    logic [SHAMT_W-1:0] amt_q, amt_d;
    logic               fill_q, fill_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    logic [2:0]         core_op;
    logic [SHAMT_W-1:0] core_amt;
    logic               core_fill;
    logic [WIDTH-1:0]   core_out;
    logic               core_shout;

    // The first step runs on the start edge itself, so in IDLE the core sees
    // the live inputs; in RUN it sees the latched setup.
    assign core_op   = (state_q == S_IDLE) ? op   : op_q;
    assign core_amt  = (state_q == S_IDLE) ? amt  : amt_q;
    assign core_fill = (state_q == S_IDLE) ? fill : fill_q;

    barrel_shift_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .in    (q_q),
        .amt   (core_amt),
        .op    (core_op),
        .fill  (core_fill),
        .out   (core_out),
        .shout (core_shout)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_d    = op_q;
        amt_d   = amt_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    q_d = d;
                end else if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        op_d   = op;
                        amt_d  = amt;
                        fill_d = fill;
                        q_d    = core_out;
                        cout_d = core_shout;
                        rem_d  = count - CNT_ONE;
                        if (count != CNT_ONE) begin
                            state_d = S_RUN;
                            busy_d  = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (load) begin
                    // Abort: no completion pulse.
                    q_d     = d;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    q_d    = core_out;
                    cout_d = core_shout;
                    rem_d  = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge preset_L) begin
        if (!preset_L) begin
            state_q <= S_IDLE;
            q_q     <= RESET_VAL;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_NOP;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
        end
    end

    assign Q    = q_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    localparam int WIDTH   = 8;
    localparam int SHAMT_W = 3;
    localparam int CNT_W   = 4;

    logic               clock = 1'b0;
    logic               preset_L;
    logic [WIDTH-1:0]   d;
    logic               load;
    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] amt;
    logic               fill;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   Q;
    logic               cout;
    logic               busy;
    logic               done;

    universal_shift_register #(
        .WIDTH     (WIDTH),
        .SHAMT_W   (SHAMT_W),
        .CNT_W     (CNT_W),
        .RESET_VAL (8'h00)
    ) dut (
        .clock    (clock),
        .preset_L (preset_L),
        .d        (d),
        .load     (load),
        .start    (start),
        .op       (op),
        .amt      (amt),
        .fill     (fill),
        .count    (count),
        .Q        (Q),
        .cout     (cout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic               ld;
        logic [WIDTH-1:0]   d;
        logic               st;
        logic [2:0]         op;
        logic [SHAMT_W-1:0] amt;
        logic               fill;
        logic [CNT_W-1:0]   cnt;
        logic [WIDTH-1:0]   eq;
        logic               ec;
        logic               eb;
        logic               ed;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    function automatic vec_t v(logic ld, logic [WIDTH-1:0] dd, logic st, logic [2:0] o,
                               logic [SHAMT_W-1:0] a, logic f, logic [CNT_W-1:0] c,
                               logic [WIDTH-1:0] eq, logic ec, logic eb, logic ed);
        vec_t r;
        r.ld = ld; r.d = dd; r.st = st; r.op = o; r.amt = a; r.fill = f; r.cnt = c;
        r.eq = eq; r.ec = ec; r.eb = eb; r.ed = ed;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(string tag, vec_t x);
        chk({tag, " Q"},    32'(Q),    32'(x.eq));
        chk({tag, " cout"}, 32'(cout), 32'(x.ec));
        chk({tag, " busy"}, 32'(busy), 32'(x.eb));
        chk({tag, " done"}, 32'(done), 32'(x.ed));
    endtask

    // Drive on the falling edge, check 1 time unit after the rising edge.
    task automatic apply(string tag, vec_t x);
        @(negedge clock);
        load = x.ld; d = x.d; start = x.st; op = x.op;
        amt = x.amt; fill = x.fill; count = x.cnt;
        @(posedge clock);
        #1;
        check_outs(tag, x);
    endtask

    initial begin
        // ld, d, st, op, amt, fill, cnt, expQ, expCout, expBusy, expDone
        // SRA single step, busy never rises
        vecs.push_back(v(1, 8'hB4, 0, 3'd0, 3'd0, 0, 4'd0, 8'hB4, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd3, 3'd2, 0, 4'd1, 8'hED, 0, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'hED, 0, 0, 0));
        // ROL x3; op/amt wiggled during RUN must be ignored
        vecs.push_back(v(1, 8'h81, 0, 3'd0, 3'd0, 0, 4'd0, 8'h81, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd4, 3'd1, 0, 4'd3, 8'h03, 1, 1, 0));
        vecs.push_back(v(0, 8'h00, 0, 3'd2, 3'd5, 1, 4'd7, 8'h06, 0, 1, 0));
        vecs.push_back(v(0, 8'h00, 0, 3'd2, 3'd5, 1, 4'd7, 8'h0C, 0, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h0C, 0, 0, 0));
        // SLL with fill=1, two steps
        vecs.push_back(v(1, 8'h01, 0, 3'd0, 3'd0, 0, 4'd0, 8'h01, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd1, 3'd3, 1, 4'd2, 8'h0F, 0, 1, 0));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h7F, 0, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h7F, 0, 0, 0));
        // ROR x5 aborted by load at step 2; start in RUN ignored; then count=0
        vecs.push_back(v(1, 8'h01, 0, 3'd0, 3'd0, 0, 4'd0, 8'h01, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd5, 3'd1, 0, 4'd5, 8'h80, 1, 1, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd1, 3'd1, 0, 4'd5, 8'h40, 0, 1, 0));
        vecs.push_back(v(1, 8'h5A, 0, 3'd0, 3'd0, 0, 4'd0, 8'h5A, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h5A, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd4, 3'd1, 0, 4'd0, 8'h5A, 0, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h5A, 0, 0, 0));
        // load wins over start in IDLE
        vecs.push_back(v(1, 8'hC3, 1, 3'd4, 3'd1, 0, 4'd3, 8'hC3, 0, 0, 0));
        // SRL fill=0 amt=5: F0 -> 07, last bit out is bit 4
        vecs.push_back(v(1, 8'hF0, 0, 3'd0, 3'd0, 0, 4'd0, 8'hF0, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd2, 3'd5, 0, 4'd1, 8'h07, 1, 0, 1));
        // load keeps cout; reserved op 110 behaves as NOP but still counts
        vecs.push_back(v(1, 8'h3C, 0, 3'd0, 3'd0, 0, 4'd0, 8'h3C, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd6, 3'd4, 0, 4'd2, 8'h3C, 0, 1, 0));
        vecs.push_back(v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h3C, 0, 0, 1));
        // ROL amt=0 counts a step, Q held, cout cleared
        vecs.push_back(v(1, 8'h81, 0, 3'd0, 3'd0, 0, 4'd0, 8'h81, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 3'd4, 3'd1, 0, 4'd1, 8'h03, 1, 0, 1));
        vecs.push_back(v(0, 8'h00, 1, 3'd4, 3'd0, 0, 4'd1, 8'h03, 0, 0, 1));

        preset_L = 1'b0;
        load = 0; d = '0; start = 0; op = '0; amt = '0; fill = 0; count = '0;
        #12;
        check_outs("reset", v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 0));
        @(negedge clock);
        preset_L = 1'b1;

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Async reset in the middle of a long ROL run
        apply("r0", v(1, 8'h81, 0, 3'd0, 3'd0, 0, 4'd0, 8'h81, 0, 0, 0));
        apply("r1", v(0, 8'h00, 1, 3'd4, 3'd1, 0, 4'd9, 8'h03, 1, 1, 0));
        apply("r2", v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h06, 0, 1, 0));
        #2;
        preset_L = 1'b0;
        #1;
        check_outs("async_rst", v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'h00, 0, 0, 0));
        @(negedge clock);
        preset_L = 1'b1;
        apply("r3", v(1, 8'hA5, 0, 3'd0, 3'd0, 0, 4'd0, 8'hA5, 0, 0, 0));
        apply("r4", v(0, 8'h00, 0, 3'd0, 3'd0, 0, 4'd0, 8'hA5, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
